// File: rtl/dmw_dtrans.sv
// dmw_dtrans: data-side direct-mapped-window translation stage.
// A single registered stage (O) backed by a one-entry skid register (S), so
// in_ready can come from a flop and the stage still streams one entry per
// cycle while the D-cache keeps accepting.
module dmw_dtrans (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dmw0,
   input  logic [31:0] dmw1,
   input  logic [1:0]  crmd_plv,
   input  logic        crmd_da,
   input  logic        crmd_pg,
   input  logic [1:0]  crmd_datm,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_vaddr,
   input  logic [5:0]  in_tag,
   input  logic        in_store,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_paddr,
   output logic [1:0]  out_mat,
   output logic        out_tlb,
   output logic [5:0]  out_tag,
   output logic        out_store
);

   typedef struct packed {
      logic [31:0] paddr;
      logic [1:0]  mat;
      logic        tlb;
      logic [5:0]  tag;
      logic        store;
   } entry_t;

   // Occupancy: EMPTY = nothing held, HALF = O only, FULL = O and S.
   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

   state_t r_state, w_state_nxt;
   entry_t r_o, r_s, w_new;
   logic   w_hit0, w_hit1, w_accept;
   logic   w_ld_o_new, w_ld_o_s, w_ld_s;
   logic   w_unused;

   // CSR fields that carry no meaning for the data-side translation.
   assign w_unused = ^{dmw0[28], dmw0[24:6], dmw0[2:1], dmw1[28], dmw1[24:6], dmw1[2:1]};

   // A window hits on VSEG match plus an enable bit for the current PLV;
   // PLV1/PLV2 have no enable bit and therefore never hit.
   assign w_hit0 = (in_vaddr[31:29] == dmw0[31:29]) &&
                   (((crmd_plv == 2'd0) && dmw0[0]) || ((crmd_plv == 2'd3) && dmw0[3]));
   assign w_hit1 = (in_vaddr[31:29] == dmw1[31:29]) &&
                   (((crmd_plv == 2'd0) && dmw1[0]) || ((crmd_plv == 2'd3) && dmw1[3]));

   // Translate the incoming address with the CSR values of this cycle; the
   // illegal da=0/pg=0 mode falls through to direct-address behaviour.
   always_comb begin
      w_new.paddr = in_vaddr;
      w_new.mat   = crmd_datm;
      w_new.tlb   = 1'b0;
      w_new.tag   = in_tag;
      w_new.store = in_store;
      if (!crmd_da && crmd_pg) begin
         if (w_hit0) begin
            w_new.paddr = {dmw0[27:25], in_vaddr[28:0]};
            w_new.mat   = dmw0[5:4];
         end else if (w_hit1) begin
            w_new.paddr = {dmw1[27:25], in_vaddr[28:0]};
            w_new.mat   = dmw1[5:4];
         end else begin
            w_new.mat   = 2'd0;
            w_new.tlb   = 1'b1;
         end
      end
   end

   assign in_ready  = (r_state != FULL);
   assign out_valid = (r_state != EMPTY);
   assign w_accept  = in_valid && in_ready;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= EMPTY;
      else        r_state <= w_state_nxt;
   end

   // Next occupancy and which register loads what; flush wins over everything.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_o_new  = 1'b0;
      w_ld_o_s    = 1'b0;
      w_ld_s      = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_ld_o_new  = 1'b1;
               w_state_nxt = HALF;
            end
         end
         HALF: begin
            if (w_accept && out_ready) begin
               w_ld_o_new = 1'b1;
            end else if (w_accept) begin
               w_ld_s      = 1'b1;
               w_state_nxt = FULL;
            end else if (out_ready) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_ready) begin
               w_ld_o_s    = 1'b1;
               w_state_nxt = HALF;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      if (flush) begin
         w_ld_o_new  = 1'b0;
         w_ld_o_s    = 1'b0;
         w_ld_s      = 1'b0;
         w_state_nxt = EMPTY;
      end
   end

   // Entry storage: O takes a new entry or the older skid entry; S only
   // ever holds the younger of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_o <= '0;
         r_s <= '0;
      end else begin
         if (w_ld_o_new)    r_o <= w_new;
         else if (w_ld_o_s) r_o <= r_s;
         if (w_ld_s)        r_s <= w_new;
      end
   end

   assign out_paddr = r_o.paddr;
   assign out_mat   = r_o.mat;
   assign out_tlb   = r_o.tlb;
   assign out_tag   = r_o.tag;
   assign out_store = r_o.store;

endmodule
